paddle_unit: RTL

PADDLE_UNIT -- requirements
Module: paddle_unit

---
 rtl/paddle_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/paddle_unit.sv
// rtl/paddle_unit.sv - paddle position/width state with animated resize and pixel generator
module paddle_unit #(
    parameter int          PD_H    = 8,
    parameter int          LEFT    = 160,
    parameter int          MAXX    = 320,
    parameter int          STEP    = 4,
    parameter int          R_MIN   = 8,
    parameter int          R_MAX   = 32,
    parameter int          R_INIT  = 16,
    parameter int          R_DELTA = 8,
    parameter logic [3:0]  COLOR   = 4'b1010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        grow,
    input  logic        shrink,
    input  logic [9:0]  y,
    input  logic [11:0] hcounter,
    input  logic [10:0] vcounter,
    output logic [9:0]  x,
    output logic [5:0]  radius,
    output logic        busy,
    output logic [3:0]  out
);

    typedef enum logic [1:0] {IDLE, GROW, SHRINK} state_t;

    localparam logic [12:0] LEFT_W  = 13'(LEFT);
    localparam logic [12:0] RIGHT_W = 13'(LEFT + MAXX);
    localparam logic [12:0] STEP_W  = 13'(STEP);
    localparam logic [9:0]  X_RST   = 10'(LEFT + MAXX / 2);
    localparam logic [5:0]  R_RST   = 6'(R_INIT);
    localparam logic [6:0]  RMIN_W  = 7'(R_MIN);
    localparam logic [6:0]  RMAX_W  = 7'(R_MAX);
    localparam logic [6:0]  RDEL_W  = 7'(R_DELTA);
    localparam logic [11:0] PDH_W   = 12'(PD_H);

    state_t      state_q, state_d;
    logic [5:0]  target_q, target_d;
    logic [5:0]  radius_q, radius_d;
    logic [9:0]  x_q, x_d;
    logic [3:0]  out_q, out_d;

    logic [6:0]  sum7, dif7, t_up, t_dn;
    logic [12:0] x13, xm, lo, hi;
    logic [11:0] x12, r12, xlo, xhi, y12, ylo, yhi, vc12;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        radius_d = radius_q;

        sum7 = {1'b0, radius_q} + RDEL_W;
        t_up = (sum7 > RMAX_W) ? RMAX_W : sum7;
        dif7 = ({1'b0, radius_q} >= RDEL_W) ? ({1'b0, radius_q} - RDEL_W) : 7'd0;
        t_dn = (dif7 < RMIN_W) ? RMIN_W : dif7;

        case (state_q)
            IDLE: begin
                if (grow && !shrink && (t_up > {1'b0, radius_q})) begin
                    state_d  = GROW;
                    target_d = t_up[5:0];
                end else if (shrink && !grow && (t_dn < {1'b0, radius_q})) begin
                    state_d  = SHRINK;
                    target_d = t_dn[5:0];
                end
            end
            GROW, SHRINK: begin
                if (frame_tick) begin
                    radius_d = (state_q == GROW) ? radius_q + 6'd1 : radius_q - 6'd1;
                    if (radius_d == target_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clamp uses the radius committed on this same tick, so growth at a wall pushes inward.
        x13 = {3'b000, x_q};
        xm  = x13;
        if (move_right && !move_left)
            xm = x13 + STEP_W;
        else if (move_left && !move_right)
            xm = (x13 >= STEP_W) ? (x13 - STEP_W) : 13'd0;
        lo = LEFT_W + {7'd0, radius_d};
        hi = RIGHT_W - {7'd0, radius_d};
        if (xm < lo)
            xm = lo;
        else if (xm > hi)
            xm = hi;
        x_d = frame_tick ? xm[9:0] : x_q;

        x12  = {2'b00, x_q};
        r12  = {6'd0, radius_q};
        xlo  = (x12 >= r12) ? (x12 - r12) : 12'd0;
        xhi  = x12 + r12;
        y12  = {2'b00, y};
        ylo  = (y12 >= PDH_W) ? (y12 - PDH_W) : 12'd0;
        yhi  = y12 + PDH_W;
        vc12 = {1'b0, vcounter};
        out_d = ((hcounter >= xlo) && (hcounter < xhi) && (vc12 >= ylo) && (vc12 < yhi))
                ? COLOR : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= R_RST;
            radius_q <= R_RST;
            x_q      <= X_RST;
            out_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            radius_q <= radius_d;
            x_q      <= x_d;
            out_q    <= out_d;
        end
    end

    assign x      = x_q;
    assign radius = radius_q;
    assign busy   = (state_q != IDLE);
    assign out    = out_q;

endmodule
